memory_access: RTL and testbench

- Pipeline memory stage. Takes an execute-stage bundle and produces the memory-stage bundle that the writeback stage consumes.
- Non-memory instructions pass the ALU result through.
- Loads and stores run a data-bus transaction, holding dbus request valid until data_ok.
- Load data is lane-aligned and extended before it reaches writeback's aluout/readdata select.
- Single-entry output buffer with valid/ready handshakes on both sides.

---
 rtl/memory_access_pkg.sv | 93 +++++++++
 rtl/memory_access_memload_extract.sv | 33 +++
 rtl/memory_access.sv | 119 +++++++++++
 tb/tb_memory_access.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage: pipeline bundles, dbus structs,
// access size encoding and small address helpers.
package memory_access_pkg;

    localparam int XLEN_PKG = 64;

    typedef logic [XLEN_PKG-1:0] word_t;
    typedef logic [7:0]          strobe_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        msize_t msize;
        logic   memsext;
    } control_t;

    typedef struct packed {
        word_t       pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        control_t    ctl;
        word_t       aluout;
        word_t       srcb;
    } execute_data_t;

    typedef struct packed {
        word_t       pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        control_t    ctl;
        word_t       aluout;
        word_t       readdata;
    } memory_data_t;

    typedef struct packed {
        logic    valid;
        word_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    // Natural alignment: the low address bits below the access size
    // must be zero.
    function automatic logic isMisaligned(
        input logic [2:0] a,
        input msize_t     s
    );
        logic r;
        unique case (s)
            MSIZE1:  r = 1'b0;
            MSIZE2:  r = a[0];
            MSIZE4:  r = |a[1:0];
            MSIZE8:  r = |a[2:0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte-enable mask of an access at lane 0.
    function automatic strobe_t sizeMask(input msize_t s);
        strobe_t m;
        unique case (s)
            MSIZE1:  m = 8'h01;
            MSIZE2:  m = 8'h03;
            MSIZE4:  m = 8'h0F;
            MSIZE8:  m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_access_memload_extract.sv
// Load data lane alignment and sign/zero extension.
// Ports: data (bus word), addr (byte offset), msize, memsext -> readdata.
module memload_extract
    import memory_access_pkg::*;
(
    input  word_t      data,
    input  logic [2:0] addr,
    input  msize_t     msize,
    input  logic       memsext,
    output word_t      readdata
);

    word_t lane;

    always_comb begin
        lane     = data >> {addr, 3'b000};
        readdata = lane;
        unique case (msize)
            MSIZE1: readdata = memsext ?
                {{56{lane[7]}}, lane[7:0]} :
                {56'b0, lane[7:0]};
            MSIZE2: readdata = memsext ?
                {{48{lane[15]}}, lane[15:0]} :
                {48'b0, lane[15:0]};
            MSIZE4: readdata = memsext ?
                {{32{lane[31]}}, lane[31:0]} :
                {32'b0, lane[31:0]};
            MSIZE8: readdata = lane;
            default: readdata = lane;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Pipeline memory stage with a single-entry output buffer.
// Ports: dataE/in_valid/in_ready in, dreq/dresp bus, dataM/out_valid/
// out_ready out, misalign flags the held bundle.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          in_valid,
    output logic          in_ready,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          misalign
);

    state_t       stateQ;
    state_t       stateD;
    memory_data_t dataMQ;
    logic         misQ;
    dbus_req_t    reqQ;
    word_t        loadData;

    logic [XLEN-1:0] addrE;
    logic            isMemE;
    logic            misE;
    logic            accept;
    logic            unusedAddrOk;

    // Requests are held until data_ok, so addr_ok carries no information.
    assign unusedAddrOk = dresp.addr_ok;

    assign addrE  = dataE.aluout;
    assign isMemE = dataE.ctl.memread | dataE.ctl.memwrite;
    assign misE   = ALIGN_CHECK && isMemE &&
                    isMisaligned(addrE[2:0], dataE.ctl.msize);

    assign in_ready = (stateQ == IDLE) ||
                      (stateQ == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    memload_extract uExtract (
        .data     (dresp.data),
        .addr     (reqQ.addr[2:0]),
        .msize    (reqQ.size),
        .memsext  (dataMQ.ctl.memsext),
        .readdata (loadData)
    );

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE, DONE: begin
                if (accept) begin
                    stateD = (isMemE && !misE) ? BUSY : DONE;
                end else if (stateQ == DONE && out_ready) begin
                    stateD = IDLE;
                end
            end
            BUSY: begin
                if (dresp.data_ok) begin
                    stateD = DONE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            dataMQ <= '0;
            misQ   <= 1'b0;
            reqQ   <= '0;
        end else begin
            stateQ <= stateD;
            if (accept) begin
                dataMQ.pc        <= dataE.pc;
                dataMQ.raw_instr <= dataE.raw_instr;
                dataMQ.dst       <= dataE.dst;
                dataMQ.ctl       <= dataE.ctl;
                dataMQ.aluout    <= dataE.aluout;
                dataMQ.readdata  <= '0;
                misQ             <= misE;
                if (isMemE && !misE) begin
                    reqQ.valid <= 1'b1;
                    reqQ.addr  <= addrE;
                    reqQ.size  <= dataE.ctl.msize;
                    if (dataE.ctl.memwrite) begin
                        reqQ.strobe <= sizeMask(dataE.ctl.msize)
                                       << addrE[2:0];
                        reqQ.data   <= dataE.srcb
                                       << {addrE[2:0], 3'b000};
                    end else begin
                        reqQ.strobe <= '0;
                        reqQ.data   <= '0;
                    end
                end
            end else if (stateQ == BUSY && dresp.data_ok) begin
                reqQ.valid <= 1'b0;
                if (dataMQ.ctl.memread) begin
                    dataMQ.readdata <= loadData;
                end
            end
        end
    end

    assign out_valid = (stateQ == DONE);
    assign dataM     = dataMQ;
    assign misalign  = misQ;
    assign dreq      = reqQ;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed vectors, a bus
// responder with wait states, and an output monitor.
module tb_memory_access;
    import memory_access_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          in_valid;
    logic          in_ready;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          out_valid;
    logic          out_ready;
    logic          misalign;

    typedef struct {
        memory_data_t d;
        logic         mis;
    } exp_t;

    exp_t      q[$];
    int        tests = 0;
    int        fails = 0;
    int        waitCycles = 0;
    word_t     respData = '0;
    logic      manualResp = 1'b0;
    logic      manualOk = 1'b0;
    int        validCycles = 0;
    dbus_req_t snap = '0;

    always #5 clk = ~clk;

    memory_access #(.XLEN(64), .ALIGN_CHECK(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dreq      (dreq),
        .dresp     (dresp),
        .dataM     (dataM),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .misalign  (misalign)
    );

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: data_ok after waitCycles request cycles.
    initial begin
        int busCnt;
        busCnt = 0;
        dresp = '0;
        dresp.addr_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (manualResp) begin
                dresp.data_ok = manualOk;
                busCnt = 0;
            end else if (dreq.valid) begin
                if (busCnt == 0) begin
                    snap = dreq;
                end else begin
                    tests++;
                    if (dreq !== snap) begin
                        fails++;
                        $display("FAIL dreq_stable: got %h expected %h",
                                 dreq.addr, snap.addr);
                    end
                end
                dresp.data_ok = (busCnt == waitCycles);
                dresp.data    = respData;
                busCnt++;
                validCycles++;
            end else begin
                dresp.data_ok = 1'b0;
                busCnt = 0;
            end
        end
    end

    // Output monitor: compare every transfer against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h expected none",
                             dataM.aluout);
                end else begin
                    e = q.pop_front();
                    check("dataM.pc", dataM.pc, e.d.pc);
                    check("dataM.aluout", dataM.aluout, e.d.aluout);
                    check("dataM.readdata", dataM.readdata,
                          e.d.readdata);
                    check("dataM.dst", 64'(dataM.dst), 64'(e.d.dst));
                    check("misalign", 64'(misalign), 64'(e.mis));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic execute_data_t mk(
        word_t pc, word_t alu, word_t srcb,
        logic rd, logic wr, msize_t sz, logic sx
    );
        execute_data_t e;
        e = '0;
        e.pc           = pc;
        e.raw_instr    = pc[31:0] ^ 32'h0000_0013;
        e.dst          = pc[6:2];
        e.ctl.regwrite = !wr;
        e.ctl.memread  = rd;
        e.ctl.memwrite = wr;
        e.ctl.msize    = sz;
        e.ctl.memsext  = sx;
        e.aluout       = alu;
        e.srcb         = srcb;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; returns at posedge+1 of the accept edge.
    task automatic send(execute_data_t e, word_t rd, logic mis,
                        output int waited);
        exp_t x;
        waited = 0;
        dataE = e;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 40) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        if (in_ready) begin
            x.d.pc        = e.pc;
            x.d.raw_instr = e.raw_instr;
            x.d.dst       = e.dst;
            x.d.ctl       = e.ctl;
            x.d.aluout    = e.aluout;
            x.d.readdata  = rd;
            x.mis         = mis;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOut(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 50);
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL out_timeout: got out_valid=0 expected 1");
        end
    endtask

    task automatic runOp(
        string name, execute_data_t e, word_t rd, logic mis,
        int wc, word_t rdata, int expLat, int expValid,
        strobe_t expStrb, word_t expData
    );
        int w;
        int lat;
        int base;
        step();
        waitCycles = wc;
        respData   = rdata;
        base       = validCycles;
        send(e, rd, mis, w);
        waitOut(lat);
        check({name, "_latency"}, 64'(lat), 64'(expLat));
        check({name, "_valid_cycles"}, 64'(validCycles - base),
              64'(expValid));
        if (expValid > 0) begin
            check({name, "_addr"}, snap.addr, e.aluout);
            check({name, "_size"}, 64'(snap.size), 64'(e.ctl.msize));
            check({name, "_strobe"}, 64'(snap.strobe), 64'(expStrb));
            if (e.ctl.memwrite) begin
                check({name, "_wdata"}, snap.data, expData);
            end
        end
    endtask

    initial begin
        int w;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dataE     = '0;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_dreq_valid", 64'(dreq.valid), 64'd0);
        check("reset_misalign", 64'(misalign), 64'd0);
        check("reset_dataM_nonzero", 64'(dataM !== '0), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        step();
        reset = 1'b1;

        runOp("alu", mk(64'h1000, 64'h1234, 64'h0, 0, 0, MSIZE8, 0),
              64'h0, 0, 0, 64'h0, 1, 0, 8'h00, 64'h0);
        runOp("lb", mk(64'h1004, 64'h8000_0003, 64'h0, 1, 0, MSIZE1, 1),
              64'hFFFF_FFFF_FFFF_FF80, 0, 3,
              64'h0000_0000_80FF_0000, 5, 4, 8'h00, 64'h0);
        runOp("sh", mk(64'h1008, 64'h8000_0006, 64'hBEEF, 0, 1,
              MSIZE2, 0), 64'h0, 0, 1, 64'h0, 3, 2, 8'hC0,
              64'hBEEF_0000_0000_0000);
        runOp("lwu", mk(64'h100C, 64'h8000_0004, 64'h0, 1, 0,
              MSIZE4, 0), 64'h0000_0000_89AB_CDEF, 0, 0,
              64'h89AB_CDEF_0123_4567, 2, 1, 8'h00, 64'h0);
        runOp("lh", mk(64'h1010, 64'h8000_0006, 64'h0, 1, 0, MSIZE2, 1),
              64'hFFFF_FFFF_FFFF_89AB, 0, 2,
              64'h89AB_CDEF_0123_4567, 4, 3, 8'h00, 64'h0);
        runOp("ld", mk(64'h1014, 64'h8000_0008, 64'h0, 1, 0, MSIZE8, 1),
              64'h0123_4567_89AB_CDEF, 0, 0,
              64'h0123_4567_89AB_CDEF, 2, 1, 8'h00, 64'h0);
        runOp("sb", mk(64'h1018, 64'h8000_0001,
              64'h1122_3344_5566_77A5, 0, 1, MSIZE1, 0), 64'h0, 0, 0,
              64'h0, 2, 1, 8'h02, 64'h2233_4455_6677_A500);
        runOp("lw_mis", mk(64'h101C, 64'h8000_0002, 64'h0, 1, 0,
              MSIZE4, 1), 64'h0, 1, 0, 64'h0, 1, 0, 8'h00, 64'h0);
        runOp("sd_mis", mk(64'h1020, 64'h8000_0004, 64'h55, 0, 1,
              MSIZE8, 0), 64'h0, 1, 0, 64'h0, 1, 0, 8'h00, 64'h0);

        // Stall in DONE, then release together with a new bundle.
        step();
        out_ready = 1'b0;
        send(mk(64'h1024, 64'hAAAA, 64'h0, 0, 0, MSIZE8, 0),
             64'h0, 0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_aluout", dataM.aluout, 64'hAAAA);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        step();
        out_ready = 1'b1;
        send(mk(64'h1028, 64'h5555, 64'h0, 0, 0, MSIZE8, 0),
             64'h0, 0, w);
        check("b2b_accept_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("b2b_no_bubble", 64'(out_valid), 64'd1);

        // Reset in the middle of a bus transaction.
        step();
        manualResp = 1'b1;
        manualOk   = 1'b0;
        send(mk(64'h102C, 64'h8000_0010, 64'h0, 1, 0, MSIZE8, 0),
             64'h0, 0, w);
        @(negedge clk);
        @(negedge clk);
        check("busy_dreq_valid", 64'(dreq.valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_dreq_valid", 64'(dreq.valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        step();
        reset = 1'b1;
        step();
        step();
        manualOk = 1'b1;
        step();
        manualOk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stale_out_valid", 64'(out_valid), 64'd0);
            check("stale_dreq_valid", 64'(dreq.valid), 64'd0);
        end
        manualResp = 1'b0;

        step();
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
